// File: rtl/switch_allocator_if.sv
// rtl/switch_allocator_if.sv - flit/route inputs, grant vector and output link bundle for the switch allocator
interface switch_allocator_if #(
  parameter int DATA_WIDTH = 8,
  parameter int N_REGISTER = 3,
  parameter int N_PORT     = 5
);
  logic [N_PORT*DATA_WIDTH-1:0] in_data;
  logic [N_PORT*N_REGISTER-1:0] in_route;
  logic [N_PORT-1:0]            s_ack;
  logic [N_PORT*DATA_WIDTH-1:0] out_data;
  logic [N_PORT-1:0]            out_valid;
  logic [N_PORT-1:0]            out_ready;

  modport master (
    output in_data, in_route, out_ready,
    input  s_ack, out_data, out_valid
  );

  modport slave (
    input  in_data, in_route, out_ready,
    output s_ack, out_data, out_valid
  );
endinterface

// File: rtl/switch_allocator.sv
// rtl/switch_allocator.sv - per-output round-robin arbitration and registered crossbar output stage
module switch_allocator #(
  parameter int DATA_WIDTH = 8,
  parameter int N_REGISTER = 3,
  parameter int N_PORT     = 5
) (
  input  logic             clk,
  input  logic             rst,
  switch_allocator_if.slave bus
);
  localparam int PW = (N_PORT > 1) ? $clog2(N_PORT) : 1;

  // Arrays indexed [output][input]
  logic [N_PORT-1:0][N_PORT-1:0]     w_req;
  logic [N_PORT-1:0]                 w_free;
  logic [N_PORT-1:0]                 w_gnt;
  logic [N_PORT-1:0][PW-1:0]         w_win;
  logic [N_PORT-1:0][DATA_WIDTH-1:0] w_wdata;
  logic [N_PORT-1:0]                 w_ack;

  logic [N_PORT-1:0][PW-1:0]         r_ptr;
  logic [N_PORT-1:0]                 r_valid;
  logic [N_PORT-1:0][DATA_WIDTH-1:0] r_data;

  function automatic logic [PW-1:0] rr_index(input logic [PW-1:0] base, input int k);
    int sum;
    sum = int'(base) + k;
    if (sum >= N_PORT) sum = sum - N_PORT;
    return PW'(sum);
  endfunction

  // Route codes at or above N_PORT never match an output index, so they are no-requests.
  always_comb begin
    w_req = '0;
    for (int p = 0; p < N_PORT; p++) begin
      for (int i = 0; i < N_PORT; i++) begin
        w_req[p][i] = (bus.in_route[i*N_REGISTER +: N_REGISTER] == N_REGISTER'(p));
      end
    end
  end

  always_comb begin
    for (int p = 0; p < N_PORT; p++) begin
      w_free[p] = !r_valid[p] || bus.out_ready[p];
    end
  end

  // Scan from farthest to nearest so the requester closest to the pointer is written last.
  always_comb begin
    w_gnt = '0;
    w_win = '0;
    for (int p = 0; p < N_PORT; p++) begin
      for (int k = N_PORT - 1; k >= 0; k--) begin
        if (w_free[p] && w_req[p][rr_index(r_ptr[p], k)]) begin
          w_gnt[p] = 1'b1;
          w_win[p] = rr_index(r_ptr[p], k);
        end
      end
    end
  end

  always_comb begin
    w_wdata = '0;
    w_ack   = '0;
    for (int p = 0; p < N_PORT; p++) begin
      for (int i = 0; i < N_PORT; i++) begin
        if (w_win[p] == PW'(i)) begin
          w_wdata[p] = bus.in_data[i*DATA_WIDTH +: DATA_WIDTH];
          if (w_gnt[p]) w_ack[i] = 1'b1;
        end
      end
    end
  end

  assign bus.s_ack     = rst ? w_ack : '0;
  assign bus.out_valid = r_valid;
  assign bus.out_data  = r_data;

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_valid <= '0;
      r_data  <= '0;
      r_ptr   <= '0;
    end else begin
      for (int p = 0; p < N_PORT; p++) begin
        if (w_gnt[p]) begin
          r_data[p]  <= w_wdata[p];
          r_valid[p] <= 1'b1;
          r_ptr[p]   <= (w_win[p] == PW'(N_PORT - 1)) ? '0 : w_win[p] + 1'b1;
        end else if (r_valid[p] && bus.out_ready[p]) begin
          r_valid[p] <= 1'b0;
        end
      end
    end
  end
endmodule

// File: tb/tb_switch_allocator.sv
// tb/tb_switch_allocator.sv - directed and random checks of switch_allocator against a round-robin reference model
module tb_switch_allocator;
  localparam int DW = 8;
  localparam int NR = 3;
  localparam int NP = 5;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  switch_allocator_if #(.DATA_WIDTH(DW), .N_REGISTER(NR), .N_PORT(NP)) bus ();

  switch_allocator #(.DATA_WIDTH(DW), .N_REGISTER(NR), .N_PORT(NP)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int total = 0;
  int bad   = 0;

  int            route [NP];
  logic [DW-1:0] dat   [NP];
  logic [NP-1:0] rdy;

  logic          m_valid [NP];
  logic [DW-1:0] m_data  [NP];
  int            m_ptr   [NP];

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic drive();
    for (int i = 0; i < NP; i++) begin
      bus.in_data[i*DW +: DW]  = dat[i];
      bus.in_route[i*NR +: NR] = NR'(route[i]);
    end
    bus.out_ready = rdy;
  endtask

  task automatic model_reset();
    for (int p = 0; p < NP; p++) begin
      m_valid[p] = 1'b0;
      m_data[p]  = '0;
      m_ptr[p]   = 0;
    end
  endtask

  task automatic set_routes(input int r0, input int r1, input int r2, input int r3, input int r4);
    route[0] = r0; route[1] = r1; route[2] = r2; route[3] = r3; route[4] = r4;
  endtask

  // One clock: compare against the model, then advance the model at the edge.
  task automatic cycle();
    logic [NP-1:0]    exp_ack;
    logic [NP-1:0]    exp_valid;
    logic [NP*DW-1:0] exp_data;
    int               winner [NP];
    int               cand;
    drive();
    #1;
    for (int p = 0; p < NP; p++) begin
      exp_valid[p]          = m_valid[p];
      exp_data[p*DW +: DW]  = m_data[p];
    end
    check("out_valid", 64'(bus.out_valid), 64'(exp_valid));
    check("out_data", 64'(bus.out_data), 64'(exp_data));
    exp_ack = '0;
    for (int p = 0; p < NP; p++) begin
      winner[p] = -1;
      if (rst && (!m_valid[p] || rdy[p])) begin
        for (int k = 0; k < NP; k++) begin
          cand = (m_ptr[p] + k) % NP;
          if (winner[p] < 0 && route[cand] == p) winner[p] = cand;
        end
      end
      if (winner[p] >= 0) exp_ack[winner[p]] = 1'b1;
    end
    check("s_ack", 64'(bus.s_ack), 64'(exp_ack));
    @(posedge clk);
    if (!rst) begin
      model_reset();
    end else begin
      for (int p = 0; p < NP; p++) begin
        if (winner[p] >= 0) begin
          m_data[p]  = dat[winner[p]];
          m_valid[p] = 1'b1;
          m_ptr[p]   = (winner[p] + 1) % NP;
        end else if (m_valid[p] && rdy[p]) begin
          m_valid[p] = 1'b0;
        end
      end
    end
    @(negedge clk);
  endtask

  int ord [6] = '{1, 2, 4, 1, 2, 4};

  initial begin
    model_reset();
    set_routes(1, 2, 3, 4, 0);
    for (int i = 0; i < NP; i++) dat[i] = DW'($urandom);
    rdy = '1;
    rst = 1'b0;
    drive();
    @(negedge clk);

    // Reset held with every input requesting
    for (int c = 0; c < 3; c++) cycle();

    // Single path: input 0 -> output 1
    rst = 1'b1;
    set_routes(1, 7, 7, 7, 7);
    dat[0] = 8'hA5;
    drive(); #1;
    check("single ack", 64'(bus.s_ack), 64'h01);
    cycle();
    check("single valid", 64'(bus.out_valid), 64'h02);
    check("single data", 64'(bus.out_data[1*DW +: DW]), 64'hA5);
    set_routes(7, 7, 7, 7, 7);
    cycle();

    // Contention on output 0 from inputs 1, 2, 4
    set_routes(7, 0, 0, 7, 0);
    for (int j = 0; j < 6; j++) begin
      for (int i = 0; i < NP; i++) dat[i] = DW'($urandom);
      drive(); #1;
      check("contention order", 64'(bus.s_ack), 64'(1 << ord[j]));
      cycle();
      check("contention data", 64'(bus.out_data[0 +: DW]), 64'(dat[ord[j]]));
    end
    set_routes(7, 7, 7, 7, 7);
    cycle();

    // Backpressure on output 3
    set_routes(3, 7, 7, 7, 7);
    dat[0] = 8'h3C;
    cycle();
    set_routes(7, 7, 3, 7, 7);
    dat[2] = 8'h77;
    rdy[3] = 1'b0;
    for (int c = 0; c < 4; c++) begin
      drive(); #1;
      check("stall data", 64'(bus.out_data[3*DW +: DW]), 64'h3C);
      check("stall ack", 64'(bus.s_ack[2]), 64'h0);
      cycle();
    end
    rdy[3] = 1'b1;
    drive(); #1;
    check("release ack", 64'(bus.s_ack[2]), 64'h1);
    cycle();
    check("release data", 64'(bus.out_data[3*DW +: DW]), 64'h77);
    check("release valid", 64'(bus.out_valid[3]), 64'h1);

    // Idle and invalid route codes
    set_routes(7, 5, 6, 7, 5);
    for (int c = 0; c < 3; c++) cycle();

    // Five parallel grants, then a one-cycle reset mid-flight
    set_routes(1, 2, 0, 4, 3);
    for (int i = 0; i < NP; i++) dat[i] = DW'($urandom);
    rdy = '1;
    drive(); #1;
    check("parallel ack", 64'(bus.s_ack), 64'h1F);
    cycle();
    check("parallel valid", 64'(bus.out_valid), 64'h1F);
    rst = 1'b0;
    cycle();
    check("midreset valid", 64'(bus.out_valid), 64'h00);
    rst = 1'b1;

    // Random traffic
    for (int c = 0; c < 400; c++) begin
      for (int i = 0; i < NP; i++) begin
        route[i] = $urandom_range(0, 7);
        dat[i]   = DW'($urandom);
      end
      for (int p = 0; p < NP; p++) rdy[p] = ($urandom_range(0, 3) != 0);
      rst = ($urandom_range(0, 59) != 0);
      cycle();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/switch_allocator.md
# switch_allocator

Router crossbar and output arbitration stage, directly downstream of the five per-port input controllers. Each controller presents a flit plus a 3-bit route code. This block arbitrates round-robin among the inputs competing for each output port. It acknowledges the winner through `s_ack`, which lets that controller pop its FIFO. The winning flit is registered onto the output link with a valid/ready handshake towards the neighbouring router or the local core.

## Interface
- `DATA_WIDTH`, 8: flit width.
- `N_REGISTER`, 3: route-code width.
- `N_PORT`, 5: number of ports. Index 0 = Local, 1 = East, 2 = West, 3 = North, 4 = South. Indices equal the route codes.
- `clk`  in  1  single clock; all state is updated on the rising edge.
- `rst`  in  1  synchronous, active-low reset, sampled on the rising edge of `clk`.
- `in_data`  in  N_PORT*DATA_WIDTH  flit from input controller i, in slice [i*DATA_WIDTH +: DATA_WIDTH].
- `in_route`  in  N_PORT*N_REGISTER  route code from input controller i, in slice [i*N_REGISTER +: N_REGISTER].
- `s_ack`  out  N_PORT  bit i is the grant to input i, which pops that input's FIFO.
- `out_data`  out  N_PORT*DATA_WIDTH  registered flit for output p.
- `out_valid`  out  N_PORT  output p holds a flit.
- `out_ready`  in  N_PORT  the downstream side of output p accepts the flit this cycle.

## Operation
- **Request decode.** Input i requests output p when `in_route[i]` equals p and p is in the range 0..4.
  - Codes 3'b101, 3'b110 and 3'b111 mean no request. 3'b111 is the controller's idle code.
  - Each input requests at most one output per cycle, so each input receives at most one grant.
- **Output free.** Output p is free when `out_valid[p]` = 0, or when `out_valid[p]` = 1 and `out_ready[p]` = 1 in the same cycle. This allows pass-through at one flit per cycle.
- **Arbitration.** Each output p has a round-robin pointer `ptr[p]` in 0..4.
  - The search starts at `ptr[p]` and goes in increasing index order, wrapping mod 5.
  - The first requesting input wins, but only if output p is free.
  - On a grant to input i, `ptr[p]` becomes (i+1) mod 5 at the next edge.
  - If there is no grant, the pointer is unchanged.
- **Grant, `s_ack`.** `s_ack[i]` is combinational. It is 1 exactly when input i wins its requested output in the current cycle. It is forced to 0 while `rst` = 0.
- **Output register for output p, at the clock edge:**
  - If it is granted: load `out_data[p]` with the winner's `in_data` and set `out_valid[p]` to 1.
  - If it is not granted and `out_valid[p]` = 1 and `out_ready[p]` = 1: set `out_valid[p]` to 0 and keep `out_data[p]`.
  - Otherwise: hold both.
- **Stall.** While `out_valid[p]` = 1 and `out_ready[p]` = 0:
  - `out_data[p]` is held stable.
  - No input is granted output p.
  - Requesters keep their request and are not acknowledged.
- **Outputs are independent.** The five output arbiters run in parallel. Up to five grants can occur in one cycle.
- **Self-route.** A request from input i to output i is legal and is treated like any other request.
- **Reset values.** While `rst` = 0:
  - all `out_valid` = 0 and all `out_data` = 0;
  - all `ptr` = 0;
  - `s_ack` = 0.
- **Reset mid-operation.** Flits held in the output registers are dropped. Pending requests are not acknowledged.

## Timing
- **Grant latency.** A request presented in cycle N to a free output gives `s_ack` = 1 in cycle N. The flit appears with `out_valid` = 1 from cycle N+1.
- **Throughput.** When `out_ready` is held high, one flit per cycle per output.
- **Data capture.** The flit is captured at the same edge at which the input controller sees `s_ack`. The value captured is `in_data` as presented in cycle N.
- **Reset release.** The first grant is possible in the first cycle in which `rst` = 1.
- **Fairness.** With k inputs continuously requesting one output that is always ready, each input is served exactly once in every k consecutive grants.

## Test plan
- **Reset.** Drive `rst` = 0 for 3 cycles with all inputs requesting. Required: `s_ack` = 0, `out_valid` = 0, `out_data` = 0 throughout.
- **Single path.** Input 0 presents route 3'b001 and data 8'hA5; `out_ready` = all ones. Required: `s_ack` = 5'b00001 in cycle N; from cycle N+1, `out_valid[1]` = 1 and `out_data[1]` = 8'hA5. The other outputs stay invalid.
- **Contention.** Inputs 1, 2 and 4 all request output 0 continuously; `out_ready[0]` = 1.
  - Required grant order: 1, 2, 4, 1, 2, 4.
  - `out_data[0]` shows the matching flits on consecutive cycles.
- **Backpressure.** Output 3 is loaded with 8'h3C. Hold `out_ready[3]` = 0 for 4 cycles while input 2 requests output 3.
  - Required: `out_data[3]` = 8'h3C is held and `s_ack[2]` = 0.
  - When `out_ready[3]` = 1, `s_ack[2]` = 1 in that same cycle, and the new flit appears on output 3 the next cycle.
- **Idle and invalid codes.** Inputs present 3'b111, 3'b101 and 3'b110. Required: no `s_ack` bit set, outputs unchanged, pointers unchanged.
- **Parallel and mid-flight reset.** Five inputs route to five distinct outputs (0→1, 1→2, 2→0, 3→4, 4→3). Required: `s_ack` = 5'b11111 and all five outputs valid the next cycle. Then assert `rst` = 0 for one cycle. Required: all `out_valid` = 0 at the following edge.
